// File: rtl/uart_tx.sv
// uart_tx - UART serial transmitter.
//
// Takes one byte per i_Tx_DV request and sends it as a frame:
// one start bit (0), 8 data bits LSB first, an optional parity bit, then
// one or two stop bits (1). Every bit is held for CLKS_PER_BIT clocks. The
// receiver uses the same CLKS_PER_BIT value, so both ends agree on baud rate.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (2..65535)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      asynchronous, active-high reset
//   i_Tx_DV      transmit request; qualifies i_Tx_Byte, only honoured in IDLE
//   i_Tx_Byte    byte to send
//   o_Tx_Active  high from the start bit through the last stop bit
//   o_Tx_Serial  serial line, idles high
//   o_Tx_Done    one-cycle pulse in the first IDLE cycle after a frame
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | line high, waiting for i_Tx_DV
// S_START    | start bit (line low)
// S_DATA     | data bit bit_idx of the latched byte
// S_PARITY   | parity bit computed when the byte was latched
// S_STOP     | stop bit stop_idx (line high)

module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        stop_idx, stop_idx_n;
    logic [7:0]  data, data_n;
    logic        par_bit, par_bit_n;
    logic        serial_n, active_n, done_n;
    logic        bit_end;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            data        <= '0;
            par_bit     <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            stop_idx    <= stop_idx_n;
            data        <= data_n;
            par_bit     <= par_bit_n;
            o_Tx_Serial <= serial_n;
            o_Tx_Active <= active_n;
            o_Tx_Done   <= done_n;
        end
    end

    assign bit_end = (cnt == CNT_LAST);

    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        data_n     = data;
        par_bit_n  = par_bit;
        done_n     = 1'b0;

        // The counter runs in every non-IDLE state and wraps at the bit end.
        if (state != S_IDLE && !bit_end) begin
            cnt_n = cnt + 16'd1;
        end

        case (state)
            S_IDLE: begin
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
                if (i_Tx_DV) begin
                    data_n    = i_Tx_Byte;
                    par_bit_n = (PARITY == 2) ? ~(^i_Tx_Byte) : (^i_Tx_Byte);
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        stop_idx_n = 1'b0;
                        state_n    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    stop_idx_n = 1'b0;
                    state_n    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state;
        // this puts the start bit on the line on the accepting edge.
        active_n = (state_n != S_IDLE);
        case (state_n)
            S_START:  serial_n = 1'b0;
            S_DATA:   serial_n = data_n[bit_idx_n];
            S_PARITY: serial_n = par_bit_n;
            default:  serial_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int NI   = 4;
    localparam int LOGN = 32768;

    typedef struct {
        int          req;
        logic [11:0] bits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int fin_count = 0;

    logic       rst [NI];
    logic       dv  [NI];
    logic [7:0] byt [NI];
    logic       act [NI];
    logic       ser [NI];
    logic       dn  [NI];

    task automatic chk(input int inst, input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL inst%0d %s actual %0d required %0d (cycle %0d)", inst, name, got, want, cyc);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int C  = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 2 : 87;
        localparam int P  = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int S  = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 2 : 1;
        localparam int NB = 9 + ((P != 0) ? 1 : 0) + S;

        uart_tx #(.CLKS_PER_BIT(C), .PARITY(P), .STOP_BITS(S)) dut (
            .i_Clock    (clk),
            .i_Reset    (rst[g]),
            .i_Tx_DV    (dv[g]),
            .i_Tx_Byte  (byt[g]),
            .o_Tx_Active(act[g]),
            .o_Tx_Serial(ser[g]),
            .o_Tx_Done  (dn[g])
        );

        exp_t q[$];
        logic log_ser [LOGN];
        logic log_act [LOGN];

        // Reference frame: bit 0 is the first bit on the line.
        function automatic logic [11:0] frame_of(input logic [7:0] b);
            logic [11:0] f;
            int ones;
            f = '1;
            ones = 0;
            f[0] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                f[1 + i] = b[i];
                ones += int'(b[i]);
            end
            if (P == 1) f[9] = ((ones % 2) == 1);
            if (P == 2) f[9] = ((ones % 2) == 0);
            return f;
        endfunction

        task automatic push(input logic [7:0] b);
            exp_t e;
            e.req  = cyc + 1;
            e.bits = frame_of(b);
            q.push_back(e);
        endtask

        always @(posedge rst[g]) q.delete();

        // Monitor: log the line every cycle, check a whole frame on o_Tx_Done.
        initial begin
            exp_t        e;
            logic [11:0] got, want;
            int          glitch, inact, len;
            forever begin
                @(negedge clk);
                if (cyc < LOGN) begin
                    log_ser[cyc] = ser[g];
                    log_act[cyc] = act[g];
                end
                if (dn[g] === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst%0d unexpected_done actual 1 required 0 (cycle %0d)", g, cyc);
                    end else begin
                        e = q.pop_front();
                        len = NB * C;
                        chk(g, "frame_len", cyc - e.req, len);
                        got = '0;
                        want = e.bits & 12'((1 << NB) - 1);
                        glitch = 0;
                        inact = 0;
                        for (int i = 0; i < NB; i++) got[i] = log_ser[e.req + i * C + C / 2];
                        for (int t = e.req; t < e.req + len; t++) begin
                            if (log_ser[t] !== e.bits[(t - e.req) / C]) glitch++;
                            if (log_act[t] !== 1'b1) inact++;
                        end
                        chk(g, "line_bits", got, want);
                        chk(g, "line_glitch_cycles", glitch, 0);
                        chk(g, "active_gap_cycles", inact, 0);
                        chk(g, "active_at_done", act[g], 0);
                    end
                end
            end
        end

        task automatic wait_done();
            int n;
            n = 0;
            while (dn[g] !== 1'b1 && n < NB * C * 2 + 20) begin
                @(negedge clk);
                n++;
            end
            if (dn[g] !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL inst%0d done_timeout actual 0 required 1 (cycle %0d)", g, cyc);
            end
        endtask

        task automatic send(input logic [7:0] b, input bit poke, input int gap);
            dv[g]  = 1'b1;
            byt[g] = b;
            push(b);
            @(negedge clk);
            dv[g]  = 1'b0;
            byt[g] = 8'($urandom);
            if (poke) begin
                repeat (C) @(negedge clk);
                dv[g]  = 1'b1;
                byt[g] = 8'h11;
                @(negedge clk);
                dv[g]  = 1'b0;
            end
            wait_done();
            repeat (gap) @(negedge clk);
        endtask

        initial begin
            int         bad, acc, n;
            bit         ok;
            logic [7:0] b;
            rst[g] = 1'b0;
            dv[g]  = 1'b0;
            byt[g] = 8'h00;
            #2;
            rst[g] = 1'b1;
            #1;
            chk(g, "reset_serial", ser[g], 1);
            chk(g, "reset_active", act[g], 0);
            chk(g, "reset_done", dn[g], 0);
            @(negedge clk);
            repeat (2) @(negedge clk);
            rst[g] = 1'b0;

            bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (ser[g] !== 1'b1 || act[g] !== 1'b0 || dn[g] !== 1'b0) bad++;
            end
            chk(g, "idle_bad_cycles", bad, 0);

            // Directed bytes; the zero gap after 8'hFF sends 8'h55 back-to-back.
            send(8'h3C, 1'b1, 2);
            send(8'hA5, 1'b1, 3);
            send(8'h07, 1'b0, 1);
            send(8'hFF, 1'b0, 0);
            send(8'h55, 1'b1, 2);
            for (int k = 0; k < 6; k++) begin
                send(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end

            // i_Tx_DV held high: each acceptance takes the byte present then.
            b = 8'($urandom);
            dv[g]  = 1'b1;
            byt[g] = b;
            push(b);
            acc = 1;
            ok = 1'b0;
            n = 0;
            while (n < 4 * NB * C + 50) begin
                @(negedge clk);
                n++;
                if (dn[g] === 1'b1) begin
                    if (acc == 3) begin
                        dv[g] = 1'b0;
                        ok = 1'b1;
                        break;
                    end
                    b = 8'($urandom);
                    byt[g] = b;
                    push(b);
                    acc++;
                end else begin
                    byt[g] = 8'($urandom);
                end
            end
            if (!ok) begin
                dv[g] = 1'b0;
                checks++;
                errors++;
                $display("FAIL inst%0d stream_timeout actual %0d required 3 (cycle %0d)", g, acc, cyc);
            end
            repeat (3) @(negedge clk);

            // Asynchronous reset in the middle of data bit 4.
            b = 8'($urandom);
            dv[g]  = 1'b1;
            byt[g] = b;
            push(b);
            @(negedge clk);
            dv[g] = 1'b0;
            repeat (5 * C) @(negedge clk);
            chk(g, "bit4_before_reset", ser[g], b[4]);
            #2;
            rst[g] = 1'b1;
            #1;
            chk(g, "abort_serial", ser[g], 1);
            chk(g, "abort_active", act[g], 0);
            repeat (3) @(negedge clk);
            rst[g] = 1'b0;
            bad = 0;
            repeat (NB * C + 5) begin
                @(negedge clk);
                if (ser[g] !== 1'b1 || dn[g] !== 1'b0 || act[g] !== 1'b0) bad++;
            end
            chk(g, "post_abort_quiet", bad, 0);
            send(8'($urandom), 1'b0, 3);

            repeat (5) @(negedge clk);
            chk(g, "pending_frames", q.size(), 0);
            fin_count++;
        end
    end

    initial begin
        fork
            begin
                wait (fin_count == NI);
            end
            begin
                #3000000;
                errors++;
                $display("FAIL global_timeout actual %0d required %0d", fin_count, NI);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
